if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register.
- Holds the PC and selects the next PC: sequential, branch/jump, eret-return or exception vector.
- Drives the instruction-memory address and checks the fetch address (AdEL).
- Produces Instr, curPC, ExcCode and BD, which the IF/ID register latches when enabled.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- EXC_VECTOR, 32'h0000_4180, handler entry on interrupt/exception.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_LIMIT, 32'h0000_6FFF, highest legal fetch byte address.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- EN  in  1  stage enable; 0 = stall (same EN that drives the IF/ID register).
- IntExcReq  in  1  interrupt/exception taken this cycle (from CP0).
- eret  in  1  eret decoded in ID.
- EPC  in  32  return address from CP0.
- jump_valid  in  1  ID resolved a taken branch or any jump.
- jump_target  in  32  redirect target from ID.
- id_is_jb  in  1  instruction now in ID is a branch/jump (delay-slot marker).
- im_addr  out  32  instruction-memory byte address (= PC).
- im_rdata  in  32  combinational instruction-memory read data.
- InstrOut  out  32  fetched instruction to IF/ID.
- curPCOut  out  32  PC of the fetched instruction.
- ExcCodeOut  out  5  fetch exception code: 0 = none, 4 = AdEL.
- BDOut  out  1  fetched instruction is in a branch delay slot.

Behaviour:
PC register:
- PC is the only state register. Reset value is PC_RESET.
- On the cycle after reset deasserts: im_addr=PC_RESET, curPCOut=PC_RESET, BDOut=0, ExcCodeOut=0, InstrOut=im_rdata.

Next-PC priority, evaluated at posedge clk, first match wins:
1. reset → PC_RESET.
2. IntExcReq → EXC_VECTOR. Overrides EN=0.
3. EN=0 → hold PC.
4. eret → EPC.
5. jump_valid → jump_target.
6. Otherwise → PC+4, 32-bit wrap, no carry-out.

Redirect latency:
- A redirect is visible on im_addr one cycle after the request is sampled.
- jump_valid does not squash the current IF instruction; it is the delay slot and proceeds normally.
- eret has no delay slot. While eret=1 and EN=1, InstrOut is forced to 0 (nop), ExcCodeOut=0 and BDOut=0, so the IF/ID register latches a bubble.

Fetch check (combinational on PC):
- AdEL when PC[1:0]≠0 or PC<IM_BASE or PC>IM_LIMIT.
- On AdEL: ExcCodeOut=5'd4, InstrOut=0, curPCOut=PC (the faulting address, for BadVAddr/EPC).
- Otherwise: ExcCodeOut=0, InstrOut=im_rdata.
- An EPC that is misaligned or out of range is not rejected at eret. It raises AdEL on the following fetch.

BD:
- BDOut = id_is_jb, except that it is forced to 0 in the eret squash case.

Outputs:
- All outputs are combinational from PC and inputs. No extra pipeline latency.
- im_addr = PC at all times, including during stall.

Simultaneous events:
- IntExcReq together with eret, jump_valid or stall → EXC_VECTOR.
- eret together with jump_valid → EPC. This cannot occur legally; the priority is defined only for determinism.

Reset mid-operation:
- Reset discards any pending redirect.
- PC returns to PC_RESET on the next edge regardless of EN or IntExcReq.

Test Plan:
1. Sequential fetch: reset 1 cycle, then EN=1 with no requests for 3 cycles → im_addr 0x3000, 0x3004, 0x3008, 0x300C; ExcCodeOut=0; BDOut=0.
2. Branch with delay slot: at PC=0x3008 drive jump_valid=1, jump_target=0x3040, id_is_jb=1 → that cycle InstrOut=im_rdata and BDOut=1; next cycle im_addr=0x3040 and BDOut=0 (id_is_jb=0).
3. Stall vs exception: hold EN=0 for 2 cycles at PC=0x3010 → PC stays 0x3010. Then pulse IntExcReq with EN=0 → next cycle im_addr=0x4180.
4. eret squash: at PC=0x4190 drive eret=1, EPC=0x3024 → same cycle InstrOut=0, ExcCodeOut=0, BDOut=0; next cycle im_addr=0x3024.
5. AdEL: jump_target=0x3042 → next cycle ExcCodeOut=4, InstrOut=0, curPCOut=0x3042. Repeat with jump_target=0x7000 and with eret to EPC=0x2FFC → ExcCodeOut=4 in each case.
6. Priority/reset: same cycle drive jump_valid=1 (0x3100), eret=1 (EPC 0x3200), IntExcReq=1 → next PC 0x4180. Next cycle assert reset with IntExcReq=1 → PC=0x3000.

Source files
------------

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the instruction memory (slave).
// The read path is combinational: im_rdata answers the im_addr of the same cycle.
interface if_fetch_stage_if;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;

    modport master (output im_addr, input im_rdata);
    modport slave  (input im_addr, output im_rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC selection and fetch-address check.
// All outputs are combinational from the PC and the current inputs.
module if_fetch_stage #(
    parameter logic [31:0] PC_RESET   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter logic [31:0] IM_LIMIT   = 32'h0000_6FFF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     EN,
    input  logic                     IntExcReq,
    input  logic                     eret,
    input  logic [31:0]              EPC,
    input  logic                     jump_valid,
    input  logic [31:0]              jump_target,
    input  logic                     id_is_jb,
    if_fetch_stage_if.master         imem,
    output logic [31:0]              InstrOut,
    output logic [31:0]              curPCOut,
    output logic [4:0]               ExcCodeOut,
    output logic                     BDOut
);

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] w_pc_seq;
    logic        w_adel;
    logic        w_squash;

    assign w_pc_seq = r_pc + 32'd4;

    // Exception entry deliberately outranks a stall; everything else waits for EN.
    always_comb begin
        w_pc_next = w_pc_seq;
        if (IntExcReq) begin
            w_pc_next = EXC_VECTOR;
        end else if (!EN) begin
            w_pc_next = r_pc;
        end else if (eret) begin
            w_pc_next = EPC;
        end else if (jump_valid) begin
            w_pc_next = jump_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= PC_RESET;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign w_adel   = (r_pc[1:0] != 2'b00) || (r_pc < IM_BASE) || (r_pc > IM_LIMIT);
    // eret has no delay slot, so the word fetched alongside it becomes a bubble.
    assign w_squash = eret && EN;

    assign imem.im_addr = r_pc;
    assign curPCOut     = r_pc;

    always_comb begin
        InstrOut   = imem.im_rdata;
        ExcCodeOut = EXC_NONE;
        BDOut      = id_is_jb;
        if (w_squash) begin
            InstrOut   = 32'd0;
            ExcCodeOut = EXC_NONE;
            BDOut      = 1'b0;
        end else if (w_adel) begin
            InstrOut   = 32'd0;
            ExcCodeOut = EXC_ADEL;
        end
    end

endmodule
